ld_combined: RTL and testbench

LD_COMBINED -- requirements
Module: ld_combined

---
 rtl/ld_pkg.sv | 21 ++
 rtl/ld_if.sv | 18 +
 rtl/ld_lane.sv | 44 ++++
 rtl/ld_combined.sv | 91 +++++++++
 tb/tb_ld_combined.sv | 144 ++++++++++++++
 5 files changed

// File: rtl/ld_pkg.sv
`default_nettype none
// ============================================================================
// Module      : ld_pkg
// Description : Shared lane-configuration encodings for the ld_combined block.
// Revision    : 1.0 - initial release
// ============================================================================
package ld_pkg;

    typedef enum logic [1:0] {
        MODE_4    = 2'b00,
        MODE_8    = 2'b01,
        MODE_16   = 2'b10,
        MODE_RSVD = 2'b11
    } mode_e;

    localparam int C_CNT_W4  = 2;
    localparam int C_CNT_W8  = 3;
    localparam int C_CNT_W16 = 4;

endpackage
`default_nettype wire

// File: rtl/ld_if.sv
`default_nettype none
// ============================================================================
// Module      : ld_if
// Description : Operand/mode in, packed run-length results out.
// Revision    : 1.0 - initial release
// ============================================================================
interface ld_if;

    logic [15:0] in;
    logic [1:0]  mode;
    logic [7:0]  count;
    logic [3:0]  valid;

    modport master (output in, output mode, input  count, input  valid);
    modport slave  (input  in, input  mode, output count, output valid);

endinterface
`default_nettype wire

// File: rtl/ld_lane.sv
`default_nettype none
// ============================================================================
// Module      : ld_lane
// Description : Regime run length of one lane: conditional invert + LZC.
// Revision    : 1.0 - initial release
// ============================================================================
module ld_lane #(
    parameter int WIDTH = 4,
    parameter int CNT_W = $clog2(WIDTH - 1)
) (
    input  wire logic [WIDTH-1:0] i_lane,
    output logic      [CNT_W-1:0] o_cnt,
    output logic                  o_vld
);

    logic [WIDTH-2:0] w_body;
    logic [CNT_W-1:0] w_cnt;
    logic             w_found;
    logic             w_unused_sign;

    assign w_unused_sign = i_lane[WIDTH-1];

    // Inverting a body that starts with 1 turns every run into a run of zeros.
    assign w_body = i_lane[WIDTH-2] ? ~i_lane[WIDTH-2:0] : i_lane[WIDTH-2:0];

    always_comb begin
        w_cnt   = '0;
        w_found = 1'b0;
        for (int k = WIDTH - 2; k >= 0; k--) begin
            if (!w_found) begin
                if (w_body[k]) begin
                    w_found = 1'b1;
                end else begin
                    w_cnt = w_cnt + CNT_W'(1);
                end
            end
        end
    end

    assign o_vld = w_found;
    assign o_cnt = w_found ? w_cnt : '0;

endmodule
`default_nettype wire

// File: rtl/ld_combined.sv
`default_nettype none
// ============================================================================
// Module      : ld_combined
// Description : SIMD leading-run detector over 4x4, 2x8 or 1x16-bit lanes.
// Revision    : 1.0 - initial release
// ============================================================================
module ld_combined
    import ld_pkg::*;
(
    input  wire logic clk,
    input  wire logic rst_n,
    ld_if.slave       bus
);

    logic [C_CNT_W4-1:0]  w_c4 [4];
    logic [3:0]           w_v4;
    logic [C_CNT_W8-1:0]  w_c8 [2];
    logic [1:0]           w_v8;
    logic [C_CNT_W16-1:0] w_c16;
    logic                 w_v16;

    logic [7:0] w_count;
    logic [3:0] w_valid;
    logic [7:0] r_count;
    logic [3:0] r_valid;

    generate
        for (genvar i = 0; i < 4; i++) begin : g_lane4
            ld_lane #(.WIDTH(4)) u_lane (
                .i_lane (bus.in[4*i +: 4]),
                .o_cnt  (w_c4[i]),
                .o_vld  (w_v4[i])
            );
        end
        for (genvar i = 0; i < 2; i++) begin : g_lane8
            ld_lane #(.WIDTH(8)) u_lane (
                .i_lane (bus.in[8*i +: 8]),
                .o_cnt  (w_c8[i]),
                .o_vld  (w_v8[i])
            );
        end
    endgenerate

    ld_lane #(.WIDTH(16)) u_lane16 (
        .i_lane (bus.in),
        .o_cnt  (w_c16),
        .o_vld  (w_v16)
    );

    always_comb begin
        w_count = '0;
        w_valid = '0;
        case (bus.mode)
            MODE_4: begin
                for (int i = 0; i < 4; i++) begin
                    w_count[2*i +: 2] = w_c4[i];
                    w_valid[i]        = w_v4[i];
                end
            end
            MODE_8: begin
                w_count[2:0] = w_c8[0];
                w_count[5:3] = w_c8[1];
                w_valid[0]   = w_v8[0];
                w_valid[2]   = w_v8[1];
            end
            MODE_16: begin
                w_count[3:0] = w_c16;
                w_valid[0]   = w_v16;
            end
            default: begin
                w_count = '0;
                w_valid = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_count <= '0;
            r_valid <= '0;
        end else begin
            r_count <= w_count;
            r_valid <= w_valid;
        end
    end

    assign bus.count = r_count;
    assign bus.valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_ld_combined.sv
`default_nettype none
// ============================================================================
// Module      : tb_ld_combined
// Description : Scoreboard bench for ld_combined (directed + random vectors).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_ld_combined;

    typedef struct packed {
        logic [7:0] count;
        logic [3:0] valid;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_fails;
    exp_t sb[$];

    ld_if bus ();

    ld_combined dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Length of the identical-bit run just below the sign bit; -1 if it fills the body.
    function automatic int run_len(input logic [15:0] v, input int w, input int lsb);
        int   n;
        logic top;
        top = v[lsb + w - 2];
        n   = 0;
        for (int k = w - 2; k >= 0; k--) begin
            if (v[lsb + k] != top) return n;
            n++;
        end
        return -1;
    endfunction

    function automatic exp_t model(input logic [15:0] v, input logic [1:0] m);
        exp_t e;
        int   r;
        e = '0;
        case (m)
            2'b00: for (int i = 0; i < 4; i++) begin
                r = run_len(v, 4, 4 * i);
                if (r >= 0) begin
                    e.count[2*i +: 2] = r[1:0];
                    e.valid[i]        = 1'b1;
                end
            end
            2'b01: for (int i = 0; i < 2; i++) begin
                r = run_len(v, 8, 8 * i);
                if (r >= 0) begin
                    e.count[3*i +: 3] = r[2:0];
                    e.valid[2*i]      = 1'b1;
                end
            end
            2'b10: begin
                r = run_len(v, 16, 0);
                if (r >= 0) begin
                    e.count[3:0] = r[3:0];
                    e.valid[0]   = 1'b1;
                end
            end
            default: e = '0;
        endcase
        return e;
    endfunction

    // Drive away from the active edge, push the expectation, pop after the edge.
    task automatic apply(input string tag, input logic rn, input logic [1:0] m,
                         input logic [15:0] v, input exp_t e);
        exp_t got_e;
        @(negedge clk);
        rst_n    = rn;
        bus.mode = m;
        bus.in   = v;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk({tag, "_sb_empty"}, 32'd0, 32'd1);
        end else begin
            got_e = sb.pop_front();
            chk({tag, "_count"}, {24'd0, bus.count}, {24'd0, got_e.count});
            chk({tag, "_valid"}, {28'd0, bus.valid}, {28'd0, got_e.valid});
        end
    endtask

    initial begin
        logic [15:0] v;
        logic [1:0]  m;
        n_checks = 0;
        n_fails  = 0;
        rst_n    = 1'b0;
        bus.mode = 2'b00;
        bus.in   = 16'h0000;

        apply("reset",       1'b0, 2'b00, 16'h27B4, '{8'h00, 4'b0000});
        apply("rst_release", 1'b1, 2'b00, 16'h27B4, '{8'h45, 4'b1011});
        apply("to_mode16",   1'b1, 2'b10, 16'h27B4, '{8'h01, 4'b0001});
        apply("m4_FEDA",     1'b1, 2'b00, 16'hFEDA, '{8'h25, 4'b0111});
        apply("m8_08F0",     1'b1, 2'b01, 16'h08F0, '{8'h1B, 4'b0101});
        apply("m8_807F",     1'b1, 2'b01, 16'h807F, '{8'h00, 4'b0000});
        apply("m16_0001",    1'b1, 2'b10, 16'h0001, '{8'h0E, 4'b0001});
        apply("m16_FFFE",    1'b1, 2'b10, 16'hFFFE, '{8'h0E, 4'b0001});
        apply("m16_4000",    1'b1, 2'b10, 16'h4000, '{8'h01, 4'b0001});
        apply("m16_7FFF",    1'b1, 2'b10, 16'h7FFF, '{8'h00, 4'b0000});
        apply("rsvd_27B4",   1'b1, 2'b11, 16'h27B4, '{8'h00, 4'b0000});
        apply("m4_max",      1'b1, 2'b00, 16'h9191, '{8'h AA, 4'b1111});
        apply("m8_max",      1'b1, 2'b01, 16'h01FE, '{8'h36, 4'b0101});
        apply("reset_mid",   1'b0, 2'b00, 16'hFEDA, '{8'h00, 4'b0000});

        for (int i = 0; i < 60; i++) begin
            v = 16'($urandom);
            m = 2'($urandom_range(0, 3));
            apply("rand", 1'b1, m, v, model(v, m));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
`default_nettype wire
